branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. Each cycle it looks up the current fetch PC and drives the predicted-next-PC path, which the PC select mux picks with PCSrc = 2'b10. Execute sends resolved branch outcomes back to it; it uses them to train the table and to keep branch and misprediction counts.

## Interface
Parameters:
- IDX_BITS, 4, log2 of BTB entry count (ENTRIES = 2^IDX_BITS)
- CNT_W, 32, width of the statistics counters

Ports:
- clk  input  1  single clock; every state element updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- PC_curr  input  32  fetch-stage PC to look up
- pred_taken  output  1  entry hit and counter predicts taken
- pred_target  output  32  predicted target; 0 when pred_taken = 0
- PCSrc_pred  output  2  2'b10 when pred_taken, else 2'b00
- upd_valid  input  1  resolved-branch update strobe from execute
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual target (meaningful only when upd_taken)
- upd_pred_taken  input  1  prediction made for this branch at fetch
- upd_pred_target  input  32  target predicted for this branch at fetch
- mispredict  output  1  registered; one-cycle pulse for a mispredicted update
- branch_count  output  CNT_W  number of updates accepted
- mispredict_count  output  CNT_W  number of mispredicted updates

## Operation
- Index = PC[IDX_BITS+1:2]. Tag = PC[31:IDX_BITS+2]. PC[1:0] is ignored.
- Each entry holds: valid, tag, 32-bit target, 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup is combinational:
  - hit = valid[idx] && tag[idx] == Tag(PC_curr)
  - pred_taken = hit && ctr[idx][1]
  - pred_target = pred_taken ? target[idx] : 0
- Update happens on a clock edge with upd_valid = 1, using index and tag of upd_pc:
  - Hit, taken: counter increments, saturating at 11; target is overwritten with upd_target.
  - Hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Miss, taken: entry is allocated; valid = 1, tag written, target = upd_target, counter = 10. Any aliasing entry is overwritten.
  - Miss, not taken: table is unchanged.
- Misprediction = (upd_taken != upd_pred_taken) || (upd_taken && upd_pred_taken && upd_target != upd_pred_target).
- Statistics:
  - branch_count increments on every update.
  - mispredict_count increments on every mispredicted update.
  - Both saturate at all-ones and never wrap.
- Reset:
  - all valid bits 0, all counters 01; tags and targets don't-care
  - branch_count = 0, mispredict_count = 0, mispredict = 0
  - pred_taken = 0, pred_target = 0, PCSrc_pred = 2'b00 from the first cycle after reset
- Reset wins over a concurrent upd_valid; that update is dropped.
- Reset in mid-operation discards all trained state.

## Timing
- Lookup latency is 0 cycles (combinational, same cycle as PC_curr).
- An update written at edge N is visible to lookups from cycle N+1 onward.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents (read-old). No bypass.
- mispredict asserts in the cycle after the edge that accepts the update, for exactly one cycle. Back-to-back mispredicted updates hold it high on consecutive cycles.
- An update is accepted on every cycle with upd_valid = 1; there is no backpressure.
- Statistics counters change at the same edge that accepts the update.

## Test plan
Defaults: IDX_BITS = 4. PC 0x40 maps to idx 0, tag 1. PC 0x80 maps to idx 0, tag 2.
- Reset check: assert rst for 2 cycles, then drive PC_curr = 0x40 → pred_taken = 0, pred_target = 0, PCSrc_pred = 00, both counts 0.
- Allocation: update pc = 0x40, taken, target 0x100, upd_pred_taken = 0 → next cycle lookup of 0x40 gives pred_taken = 1, pred_target = 0x100, PCSrc_pred = 10; mispredict pulses once; branch_count = 1, mispredict_count = 1.
- Counter training: starting from the allocated entry (counter 10), apply two not-taken updates for 0x40 → after the first, pred_taken = 0 (counter 01); after the second, counter 00. Then two taken updates → pred_taken = 0 after the first (01), 1 after the second (10).
- Aliasing and same-cycle update: with 0x40 trained taken, update pc = 0x80, taken, target 0x200 while looking up 0x40 in that same cycle → that cycle still shows pred_target = 0x100. Next cycle: 0x40 misses (pred_taken = 0), and 0x80 hits with target 0x200.
- Target change and saturation: with 0x40 at counter 11 and a correct prediction of target 0x100, update it taken to 0x300 → mispredict pulses and the stored target becomes 0x300. With CNT_W = 4, 20 updates → branch_count holds at 15.
- Reset mid-training: assert rst in the same cycle as upd_valid → that update is dropped, all entries miss, and both counts are 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and execute update signals of the branch predictor
interface branch_predictor_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      PC_curr;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [1:0]       PCSrc_pred;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_pred_taken;
    logic [31:0]      upd_pred_target;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output PC_curr, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, PCSrc_pred, mispredict,
               branch_count, mispredict_count
    );

    modport slave (
        input  PC_curr, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, PCSrc_pred, mispredict,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating counters and branch statistics
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 32
) (
    input logic           clk,
    input logic           rst,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0]       valid_q, valid_d;
    logic [ENTRIES-1:0][1:0]  ctr_q, ctr_d;
    logic [TAG_W-1:0]         tag_q [ENTRIES];
    logic [TAG_W-1:0]         tag_d [ENTRIES];
    logic [31:0]              target_q [ENTRIES];
    logic [31:0]              target_d [ENTRIES];
    logic                     mispredict_q, mispredict_d;
    logic [CNT_W-1:0]         branch_count_q, branch_count_d;
    logic [CNT_W-1:0]         mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0]      lk_idx, up_idx;
    logic [TAG_W-1:0]         lk_tag, up_tag;
    logic                     lk_hit, lk_taken, up_hit, up_mis;

    // Lookup reads registered state only, so a same-cycle update is not bypassed
    always_comb begin
        lk_idx   = bp.PC_curr[IDX_BITS+1:2];
        lk_tag   = bp.PC_curr[31:IDX_BITS+2];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][1];
    end

    assign bp.pred_taken       = lk_taken;
    assign bp.pred_target      = lk_taken ? target_q[lk_idx] : 32'h0;
    assign bp.PCSrc_pred       = lk_taken ? 2'b10 : 2'b00;
    assign bp.mispredict       = mispredict_q;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

    always_comb begin
        up_idx = bp.upd_pc[IDX_BITS+1:2];
        up_tag = bp.upd_pc[31:IDX_BITS+2];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_mis = (bp.upd_taken != bp.upd_pred_taken) ||
                 (bp.upd_taken && bp.upd_pred_taken &&
                  (bp.upd_target != bp.upd_pred_target));
    end

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (bp.upd_valid) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    target_d[up_idx] = bp.upd_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocation evicts whatever aliasing branch held this slot
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.upd_target;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    always_comb begin
        mispredict_d       = bp.upd_valid && up_mis;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bp.upd_valid && (branch_count_q != {CNT_W{1'b1}})) begin
            branch_count_d = branch_count_q + CNT_W'(1);
        end
        if (mispredict_d && (mispredict_count_q != {CNT_W{1'b1}})) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q            <= '0;
            ctr_q              <= {ENTRIES{2'b01}};
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            ctr_q              <= ctr_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they need no reset
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end
endmodule
